// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display conversion path.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int          MAX_VALUE = 9999;
   localparam logic [15:0] SAT_BCD   = 16'h9999;

endpackage

// File: rtl/dabble_nibble.sv
// One BCD digit correction step: adds 3 when the digit is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module dabble_nibble (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: one input bit per clock, result loaded on
// entry to DONE, saturating to all-nines when the value exceeds MAX_VALUE.
module bin_to_bcd_converter #(
   parameter int NUM_BITS   = 16,
   parameter int NUM_DIGITS = 4,
   parameter int MAX_VALUE  = bcd_pkg::MAX_VALUE
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NUM_BITS-1:0]     iBinary,
   output logic [4*NUM_DIGITS-1:0] oBCD,
   output logic                    oBusy,
   output logic                    oDone,
   output logic                    oOverflow
);

   import bcd_pkg::*;

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int SCR_W = BCD_W + NUM_BITS;
   localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [CNT_W-1:0]    LAST_COUNT = CNT_W'(NUM_BITS - 1);
   localparam logic [NUM_BITS-1:0] MAX_BIN    = NUM_BITS'(MAX_VALUE);
   localparam logic [BCD_W-1:0]    SAT_VALUE  = {NUM_DIGITS{4'h9}};

   state_t            state_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [SCR_W-1:0]  scratch_reg;
   logic              sat_reg;

   logic [BCD_W-1:0]  adjusted;
   logic [SCR_W-1:0]  shifted;
   logic              accept;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         dabble_nibble u_nibble (
            .din  (scratch_reg[NUM_BITS + 4*gi +: 4]),
            .dout (adjusted[4*gi +: 4])
         );
      end
   endgenerate

   // Correct every digit first, then shift the whole scratch (digits + binary) left.
   assign shifted = {adjusted, scratch_reg[NUM_BITS-1:0]} << 1;
   assign accept  = start && (state_reg != SHIFT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         scratch_reg <= '0;
         sat_reg     <= 1'b0;
         oBCD        <= '0;
         oBusy       <= 1'b0;
         oDone       <= 1'b0;
         oOverflow   <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  scratch_reg <= {{BCD_W{1'b0}}, iBinary};
                  count_reg   <= '0;
                  sat_reg     <= (iBinary > MAX_BIN);
                  state_reg   <= SHIFT;
                  oBusy       <= 1'b1;
               end else begin
                  state_reg   <= IDLE;
               end
            end
            SHIFT: begin
               scratch_reg <= shifted;
               count_reg   <= count_reg + 1'b1;
               if (count_reg == LAST_COUNT) begin
                  state_reg <= DONE;
                  oBusy     <= 1'b0;
                  oDone     <= 1'b1;
                  oBCD      <= sat_reg ? SAT_VALUE : shifted[SCR_W-1 -: BCD_W];
                  oOverflow <= sat_reg;
               end
            end
            default: begin
               state_reg <= IDLE;
               oBusy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Inverse of the duration register's BCD-to-binary load path.
- Converts the datapath's 16-bit binary remaining-time/count value back into 4 packed BCD digits for the HEX/VGA display path.
- Saturates to 9999 when the input exceeds the 4-digit range.

Parameters:
- NUM_BITS, 16, width of binary input; also the number of shift iterations.
- NUM_DIGITS, 4, number of BCD output digits; oBCD width is 4*NUM_DIGITS.
- MAX_VALUE, 9999, largest representable value; inputs above it saturate.

Ports:
- clock  input  1  system clock (50 MHz on board).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled on posedge clock when oBusy==0.
- iBinary  input  NUM_BITS  unsigned binary value, captured on the accepted start.
- oBCD  output  4*NUM_DIGITS  packed BCD result, [15:12]=thousands … [3:0]=ones; held between conversions.
- oBusy  output  1  high while a conversion is in progress.
- oDone  output  1  one-cycle pulse; oBCD is valid in that same cycle.
- oOverflow  output  1  captured iBinary > MAX_VALUE; updated with oDone and held.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, shift counter=0, scratch=0, oBCD=0, oBusy=0, oDone=0, oOverflow=0.
- States:
  - IDLE: wait for start.
  - SHIFT: NUM_BITS iterations, one per cycle.
  - DONE: single cycle; outputs update.
- Transitions:
  - IDLE→SHIFT on start.
  - SHIFT→SHIFT while counter < NUM_BITS-1.
  - SHIFT→DONE when counter == NUM_BITS-1.
  - DONE→SHIFT if start, else DONE→IDLE.
- Accept rule: start is honoured only in IDLE or DONE (oBusy==0). Start during SHIFT is ignored and not queued.
- Capture on accept:
  - scratch = {4*NUM_DIGITS zero bits, iBinary}, counter=0.
  - sat flag = (iBinary > MAX_VALUE).
- SHIFT cycle, done combinationally on the current scratch:
  - each BCD nibble ≥5 gets +3 (4-bit add, no carry out);
  - then the full scratch shifts left by 1;
  - counter increments.
- Latency:
  - start accepted at edge N; oBusy high for cycles N+1..N+NUM_BITS (16 cycles).
  - oDone=1 in cycle N+NUM_BITS+1 (17th cycle after accept); oBusy=0 in DONE.
- Result load, on the DONE entry edge:
  - oBCD = upper BCD field of scratch if sat==0, else 16'h9999.
  - oOverflow = sat.
- oBCD and oOverflow hold until the next DONE. They are not cleared on start.
- Back-to-back: start in the DONE cycle begins the next conversion with no idle gap; oDone still pulses for exactly one cycle.
- iBinary may change freely after capture; the result depends only on the captured value.
- Reset mid-conversion: aborts immediately to reset values. No oDone is produced for the aborted conversion.
- Nibble arithmetic stays 4-bit; invalid nibbles (>9) cannot occur for inputs ≤ MAX_VALUE. The sat path masks the >MAX_VALUE case.

Decomposition:
- Shared package (bcd_pkg):
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - MAX_VALUE constant;
  - SAT_BCD = 16'h9999.
- One combinational sub-module, dabble_nibble: 4-bit in/out, adds 3 when in ≥5. Instantiated NUM_DIGITS times via generate.
- Counter, FSM and scratch register stay in the top module.

Test Plan:
- Reset released, start=1 for one cycle with iBinary=16'd1234 → oBusy high for 16 cycles; oDone pulses on cycle 17; oBCD=16'h1234, oOverflow=0.
- iBinary=0, then 9999 → oBCD=16'h0000, then 16'h9999, oOverflow=0 both times; exactly one oDone pulse each.
- iBinary=10000, then 65535 → oBCD=16'h9999, oOverflow=1; a following conversion of 42 → oBCD=16'h0042, oOverflow=0.
- Start 567, then pulse start with iBinary=8888 on cycle 5 (busy) → ignored; result 16'h0567 at cycle 17. Start asserted during the DONE cycle with 8888 → next oDone 17 cycles later with 16'h8888.
- Drive reset low at cycle 8 of a conversion of 4321 → all outputs 0 immediately; no oDone. After release, a new start with 4321 → 16'h4321.
- Randomised sweep 0..9999 against a reference model (digit = (v/10^k)%10) → exact match; one oDone per accepted start.
